// File: rtl/reg_file_rd_if.sv
// Decode/writeback bus of the operand-stage register file.
// master drives read requests and writeback; slave returns the registered operands.
interface reg_file_rd_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 3
);
    logic              en_in;
    logic [AWIDTH-1:0] rd_addr;
    logic [AWIDTH-1:0] rs_addr;
    logic              wb_en;
    logic [AWIDTH-1:0] wb_addr;
    logic [DWIDTH-1:0] wb_data;
    logic [DWIDTH-1:0] rd_q;
    logic [DWIDTH-1:0] rs_q;
    logic              en_out;

    modport master (
        output en_in, rd_addr, rs_addr, wb_en, wb_addr, wb_data,
        input  rd_q, rs_q, en_out
    );

    modport slave (
        input  en_in, rd_addr, rs_addr, wb_en, wb_addr, wb_data,
        output rd_q, rs_q, en_out
    );
endinterface

// File: rtl/reg_file_rd.sv
// Dual-read, single-write register file with write-first forwarding and
// registered operand outputs plus a one-cycle valid toward the ALU operand mux.
module reg_file_rd #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned AWIDTH  = 3,
    parameter bit          R0_ZERO = 1'b1
) (
    input logic          clk,
    input logic          rst_n,
    reg_file_rd_if.slave bus
);
    localparam int unsigned NREGS = 2 ** AWIDTH;

    logic [DWIDTH-1:0] mem_q [NREGS];
    logic [DWIDTH-1:0] rd_q_q, rs_q_q;
    logic [DWIDTH-1:0] rd_src, rs_src;
    logic              en_out_q;
    logic              wr_ok;

    // A write to r0 is dropped when r0 is hardwired to zero.
    assign wr_ok = bus.wb_en && !(R0_ZERO && (bus.wb_addr == '0));

    always_comb begin
        rd_src = mem_q[bus.rd_addr];
        rs_src = mem_q[bus.rs_addr];
        if (bus.wb_en && (bus.wb_addr == bus.rd_addr)) begin
            rd_src = bus.wb_data;
        end
        if (bus.wb_en && (bus.wb_addr == bus.rs_addr)) begin
            rs_src = bus.wb_data;
        end
        if (R0_ZERO && (bus.rd_addr == '0)) begin
            rd_src = '0;
        end
        if (R0_ZERO && (bus.rs_addr == '0)) begin
            rs_src = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q_q   <= '0;
            rs_q_q   <= '0;
            en_out_q <= 1'b0;
        end else begin
            en_out_q <= bus.en_in;
            if (bus.en_in) begin
                rd_q_q <= rd_src;
                rs_q_q <= rs_src;
            end
        end
    end

    assign bus.rd_q   = rd_q_q;
    assign bus.rs_q   = rs_q_q;
    assign bus.en_out = en_out_q;
endmodule

// File: tb/tb_reg_file_rd.sv
// Directed bench for reg_file_rd: reads push expected operands into a scoreboard
// queue; a negedge monitor pops and compares whenever en_out is high.
module tb_reg_file_rd;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 3;

    typedef struct packed {
        logic [DW-1:0] rd;
        logic [DW-1:0] rs;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t sb[$];

    reg_file_rd_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    reg_file_rd #(.DWIDTH(DW), .AWIDTH(AW), .R0_ZERO(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    // Monitor: every valid output must match the oldest outstanding read.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.en_out === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_en_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rd_q", {16'h0, bus.rd_q}, {16'h0, e.rd});
                    check("rs_q", {16'h0, bus.rs_q}, {16'h0, e.rs});
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
    task automatic cyc(input logic en, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [DW-1:0] exp_rd, input logic [DW-1:0] exp_rs);
        bus.en_in   = en;
        bus.rd_addr = ra;
        bus.rs_addr = rb;
        bus.wb_en   = we;
        bus.wb_addr = wa;
        bus.wb_data = wd;
        if (en) sb.push_back('{rd: exp_rd, rs: exp_rs});
        @(posedge clk);
        #1;
        bus.en_in = 1'b0;
        bus.wb_en = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        cyc(1'b0, '0, '0, 1'b1, wa, wd, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [DW-1:0] exp_rd, input logic [DW-1:0] exp_rs);
        cyc(1'b1, ra, rb, 1'b0, '0, '0, exp_rd, exp_rs);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.en_in   = 1'b0;
        bus.rd_addr = '0;
        bus.rs_addr = '0;
        bus.wb_en   = 1'b0;
        bus.wb_addr = '0;
        bus.wb_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rd_q", {16'h0, bus.rd_q}, 32'h0);
        check("reset_rs_q", {16'h0, bus.rs_q}, 32'h0);
        check("reset_en_out", {31'h0, bus.en_out}, 32'h0);
        rst_n = 1'b1;

        // Asynchronous reset mid-cycle clears outputs and memory.
        wr(3'd3, 16'hBEEF);
        rd(3'd3, 3'd3, 16'hBEEF, 16'hBEEF);
        bus.en_in   = 1'b1;
        bus.rd_addr = 3'd3;
        bus.rs_addr = 3'd3;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_rd_q", {16'h0, bus.rd_q}, 32'h0);
        check("async_rst_rs_q", {16'h0, bus.rs_q}, 32'h0);
        check("async_rst_en_out", {31'h0, bus.en_out}, 32'h0);
        bus.en_in = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rd(3'd3, 3'd3, 16'h0000, 16'h0000);

        // Basic write then read, followed by idle with a write into r1.
        wr(3'd1, 16'h1234);
        wr(3'd2, 16'hABCD);
        rd(3'd1, 3'd2, 16'h1234, 16'hABCD);
        for (int i = 0; i < 3; i++) begin
            wr(3'd1, 16'h9999);
            check("idle_en_out", {31'h0, bus.en_out}, 32'h0);
            check("idle_rd_hold", {16'h0, bus.rd_q}, 32'h1234);
        end
        rd(3'd1, 3'd1, 16'h9999, 16'h9999);

        // Write-first forwarding, then the same value from storage.
        wr(3'd5, 16'h0001);
        cyc(1'b1, 3'd5, 3'd5, 1'b1, 3'd5, 16'h5555, 16'h5555, 16'h5555);
        rd(3'd5, 3'd0, 16'h5555, 16'h0000);
        cyc(1'b1, 3'd6, 3'd7, 1'b1, 3'd6, 16'h6666, 16'h6666, 16'h0000);

        // r0 stays zero, including a same-cycle write.
        wr(3'd0, 16'hFFFF);
        rd(3'd0, 3'd0, 16'h0000, 16'h0000);
        cyc(1'b1, 3'd0, 3'd1, 1'b1, 3'd0, 16'h7777, 16'h0000, 16'h9999);

        // Back-to-back reads keep en_out high and the data stepping.
        wr(3'd1, 16'h0011);
        wr(3'd2, 16'h0022);
        wr(3'd3, 16'h0033);
        wr(3'd4, 16'h0044);
        rd(3'd1, 3'd4, 16'h0011, 16'h0044);
        check("b2b_en_out0", {31'h0, bus.en_out}, 32'h1);
        rd(3'd2, 3'd3, 16'h0022, 16'h0033);
        check("b2b_en_out1", {31'h0, bus.en_out}, 32'h1);
        rd(3'd3, 3'd2, 16'h0033, 16'h0022);
        check("b2b_en_out2", {31'h0, bus.en_out}, 32'h1);
        rd(3'd4, 3'd1, 16'h0044, 16'h0011);
        check("b2b_en_out3", {31'h0, bus.en_out}, 32'h1);
        @(posedge clk);
        #1;
        check("b2b_en_out_drop", {31'h0, bus.en_out}, 32'h0);

        repeat (2) @(posedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
